// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer slice: FSM state type and
// default word width / slot count.
package tdm_pkg;

   localparam int DEF_WIDTH = 5;
   localparam int DEF_NCH   = 4;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NCH slot counter for the TDM demultiplexer. NCH is a power of two,
// so the natural binary wrap of the counter gives the modulo behaviour.
// Priority: clear over load-to-one over increment.
module tdm_slot_counter #(
   parameter int NCH = 4,
   parameter int SW  = $clog2(NCH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          load_one,
   input  logic          incr,
   output logic [SW-1:0] slot
);

   // Slot register: clear wins, then a frame-start load, then the normal advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else if (clear) begin
         slot <= '0;
      end else if (load_one) begin
         slot <= SW'(1);
      end else if (incr) begin
         slot <= slot + 1'b1;
      end
   end

endmodule

// File: rtl/tdm_demux_4ch.sv
// TDM demultiplexer: splits a slot-interleaved word stream into NCH channel
// registers, tracking frame alignment with a HUNT/LOCKED state machine.
// Optional feature: define TDM_PARITY_EN to check even parity on every
// captured word and report mismatches per channel on par_err.
module tdm_demux_4ch
   import tdm_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NCH   = DEF_NCH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     din,
   input  logic                 din_valid,
   input  logic                 frame_sync,
   input  logic                 din_par,
   output logic [NCH*WIDTH-1:0] ch_data,
   output logic [NCH-1:0]       ch_valid,
   output logic                 frame_done,
   output logic                 locked,
   output logic                 sync_err,
   output logic [NCH-1:0]       par_err
);

   localparam int SW = $clog2(NCH);

   tdm_state_t          state_q;
   tdm_state_t          state_d;
   logic [SW-1:0]       slot;
   logic                ctr_clear;
   logic                ctr_load_one;
   logic                ctr_incr;
   logic                cap_en;
   logic [SW-1:0]       cap_idx;
   logic [NCH-1:0]      valid_d;
   logic                frame_done_d;
   logic                sync_err_d;

   logic [NCH*WIDTH-1:0] ch_data_q;
   logic [NCH-1:0]       ch_valid_q;
   logic                 frame_done_q;
   logic                 sync_err_q;

   tdm_slot_counter #(
      .NCH (NCH),
      .SW  (SW)
   ) u_slot_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (ctr_clear),
      .load_one (ctr_load_one),
      .incr     (ctr_incr),
      .slot     (slot)
   );

   // State register for the frame alignment FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Decide what the current valid word does: capture, error, or discard.
   // A frame_sync word always restarts the frame at channel 0; a sync that
   // arrives early is flagged but still honoured so we realign immediately.
   always_comb begin
      state_d      = state_q;
      cap_en       = 1'b0;
      cap_idx      = '0;
      valid_d      = '0;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      ctr_clear    = 1'b0;
      ctr_load_one = 1'b0;
      ctr_incr     = 1'b0;
      if (din_valid) begin
         case (state_q)
            HUNT: begin
               if (frame_sync) begin
                  cap_en       = 1'b1;
                  ctr_load_one = 1'b1;
                  state_d      = LOCKED;
               end
            end
            LOCKED: begin
               if (frame_sync) begin
                  cap_en       = 1'b1;
                  ctr_load_one = 1'b1;
                  sync_err_d   = (slot != '0);
               end else if (slot == '0) begin
                  sync_err_d = 1'b1;
                  ctr_clear  = 1'b1;
                  state_d    = HUNT;
               end else begin
                  cap_en       = 1'b1;
                  cap_idx      = slot;
                  ctr_incr     = 1'b1;
                  frame_done_d = (slot == SW'(NCH - 1));
               end
            end
            default: begin
               state_d   = HUNT;
               ctr_clear = 1'b1;
            end
         endcase
      end
      if (cap_en) begin
         valid_d[cap_idx] = 1'b1;
      end
   end

   // Channel registers hold their contents until the same slot is captured again
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_data_q <= '0;
      end else if (cap_en) begin
         ch_data_q[int'(cap_idx)*WIDTH +: WIDTH] <= din;
      end
   end

   // Registered one-cycle pulses; idle cycles clear them because the decode
   // defaults everything to zero when din_valid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_valid_q   <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         ch_valid_q   <= valid_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

`ifdef TDM_PARITY_EN
   logic           par_bad;
   logic [NCH-1:0] par_err_q;

   assign par_bad = ^{din, din_par};

   // Parity flag rides alongside the channel strobe; data is captured regardless
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err_q <= '0;
      end else begin
         par_err_q <= par_bad ? valid_d : '0;
      end
   end

   assign par_err = par_err_q;
`else
   logic unused_din_par;

   assign unused_din_par = din_par;
   assign par_err        = '0;
`endif

   assign ch_data    = ch_data_q;
   assign ch_valid   = ch_valid_q;
   assign frame_done = frame_done_q;
   assign sync_err   = sync_err_q;
   assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed scenarios plus a random
// stream compared against a behavioural frame model. Honours TDM_PARITY_EN.
module tb_tdm_demux_4ch;

   localparam int WIDTH = 5;
   localparam int NCH   = 4;
   localparam int VW    = NCH*WIDTH + NCH + 3 + NCH;

   logic                 clk;
   logic                 rst_n;
   logic [WIDTH-1:0]     din;
   logic                 din_valid;
   logic                 frame_sync;
   logic                 din_par;
   logic [NCH*WIDTH-1:0] ch_data;
   logic [NCH-1:0]       ch_valid;
   logic                 frame_done;
   logic                 locked;
   logic                 sync_err;
   logic [NCH-1:0]       par_err;

   int n_checks;
   int n_fail;

   // Behavioural model: alignment flag, expected slot, channel contents, pulses
   bit               m_locked;
   int               m_slot;
   logic [WIDTH-1:0] m_ch [NCH];
   logic [NCH-1:0]   e_valid;
   logic             e_fd;
   logic             e_se;
   logic [NCH-1:0]   e_par;

   tdm_demux_4ch #(
      .WIDTH (WIDTH),
      .NCH   (NCH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .din_par    (din_par),
      .ch_data    (ch_data),
      .ch_valid   (ch_valid),
      .frame_done (frame_done),
      .locked     (locked),
      .sync_err   (sync_err),
      .par_err    (par_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NCH*WIDTH-1:0] model_data();
      logic [NCH*WIDTH-1:0] v;
      v = '0;
      for (int k = 0; k < NCH; k++) v[k*WIDTH +: WIDTH] = m_ch[k];
      return v;
   endfunction

   function automatic logic [VW-1:0] model_vec();
      return {model_data(), e_valid, e_fd, e_se, logic'(m_locked), e_par};
   endfunction

   task automatic model_reset();
      m_locked = 0;
      m_slot   = 0;
      for (int k = 0; k < NCH; k++) m_ch[k] = '0;
      e_valid = '0; e_fd = 0; e_se = 0; e_par = '0;
   endtask

   task automatic model_capture(input int k, input logic [WIDTH-1:0] d, input logic p);
      m_ch[k]    = d;
      e_valid[k] = 1'b1;
`ifdef TDM_PARITY_EN
      if (^{d, p}) e_par[k] = 1'b1;
`else
      if (p === 1'bx) e_par = '0;
`endif
   endtask

   task automatic model_step(input logic v, input logic fs, input logic [WIDTH-1:0] d, input logic p);
      e_valid = '0; e_fd = 0; e_se = 0; e_par = '0;
      if (v) begin
         if (!m_locked) begin
            if (fs) begin
               model_capture(0, d, p);
               m_slot   = 1;
               m_locked = 1;
            end
         end else if (fs) begin
            if (m_slot != 0) e_se = 1;
            model_capture(0, d, p);
            m_slot = 1;
         end else if (m_slot == 0) begin
            e_se     = 1;
            m_locked = 0;
         end else begin
            model_capture(m_slot, d, p);
            if (m_slot == NCH-1) e_fd = 1;
            m_slot = (m_slot + 1) % NCH;
         end
      end
   endtask

   // Drive one word for one clock and advance the model; returns at the next negedge
   task automatic applyStimulus(input logic v, input logic fs, input logic [WIDTH-1:0] d, input logic p);
      din_valid  = v;
      frame_sync = fs;
      din        = d;
      din_par    = p;
      model_step(v, fs, d, p);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (ch_data !== '0) begin n_fail++; $display("[TB] FAIL reset_ch_data: got %h expected 0", ch_data); end
      n_checks++;
      if ({ch_valid, frame_done, sync_err, locked, par_err} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got valid=%b fd=%b se=%b lk=%b par=%b expected all 0",
                  ch_valid, frame_done, sync_err, locked, par_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_frame();
      logic [NCH-1:0] exp_v;
      for (int i = 0; i < NCH; i++) begin
         logic [WIDTH-1:0] d;
         d = WIDTH'(i + 1);
         applyStimulus(1'b1, (i == 0), d, ^d);
         exp_v = NCH'(1) << i;
         n_checks++;
         if (ch_valid !== exp_v || frame_done !== (i == NCH-1) || par_err !== '0) begin
            n_fail++;
            $display("[TB] FAIL basic_slot%0d: got valid=%b fd=%b par=%b expected valid=%b fd=%b par=0",
                     i, ch_valid, frame_done, par_err, exp_v, (i == NCH-1));
         end
      end
      n_checks++;
      if (ch_data !== {5'h04, 5'h03, 5'h02, 5'h01} || locked !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL basic_data: got %h locked=%b expected %h locked=1",
                  ch_data, locked, {5'h04, 5'h03, 5'h02, 5'h01});
      end
   endtask

   task automatic test_gaps();
      int pulses;
      pulses = 0;
      test_reset();
      for (int i = 0; i < NCH; i++) begin
         logic [WIDTH-1:0] d;
         d = WIDTH'(i + 1);
         applyStimulus(1'b1, (i == 0), d, ^d);
         for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b0, 1'b0, 5'h1F, 1'b0);
            if (ch_valid !== '0 || frame_done !== 1'b0 || sync_err !== 1'b0) pulses++;
         end
      end
      n_checks++;
      if (pulses != 0) begin n_fail++; $display("[TB] FAIL gaps_pulses: got %0d pulsing gap cycles expected 0", pulses); end
      n_checks++;
      if (ch_data !== {5'h04, 5'h03, 5'h02, 5'h01} || locked !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL gaps_data: got %h locked=%b expected %h locked=1",
                  ch_data, locked, {5'h04, 5'h03, 5'h02, 5'h01});
      end
   endtask

   task automatic test_hunt_discard();
      test_reset();
      applyStimulus(1'b1, 1'b0, 5'h1F, 1'b1);
      n_checks++;
      if (ch_valid !== '0 || locked !== 1'b0 || sync_err !== 1'b0) begin
         n_fail++; $display("[TB] FAIL hunt_1F: got valid=%b lk=%b se=%b expected 0/0/0", ch_valid, locked, sync_err);
      end
      applyStimulus(1'b1, 1'b0, 5'h1E, 1'b0);
      n_checks++;
      if (ch_valid !== '0 || locked !== 1'b0 || ch_data !== '0) begin
         n_fail++; $display("[TB] FAIL hunt_1E: got valid=%b lk=%b data=%h expected 0/0/0", ch_valid, locked, ch_data);
      end
      applyStimulus(1'b1, 1'b1, 5'h07, 1'b1);
      n_checks++;
      if (ch_data[4:0] !== 5'h07 || locked !== 1'b1 || ch_valid !== 4'b0001) begin
         n_fail++; $display("[TB] FAIL hunt_sync: got ch0=%h lk=%b valid=%b expected 07/1/0001", ch_data[4:0], locked, ch_valid);
      end
   endtask

   task automatic test_early_sync();
      applyStimulus(1'b1, 1'b0, 5'h11, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'h0A, 1'b0);
      n_checks++;
      if (sync_err !== 1'b1 || ch_data[4:0] !== 5'h0A || frame_done !== 1'b0 || ch_valid !== 4'b0001) begin
         n_fail++;
         $display("[TB] FAIL early_sync: got se=%b ch0=%h fd=%b valid=%b expected 1/0A/0/0001",
                  sync_err, ch_data[4:0], frame_done, ch_valid);
      end
      applyStimulus(1'b1, 1'b0, 5'h15, 1'b1);
      n_checks++;
      if (ch_valid !== 4'b0010 || ch_data[9:5] !== 5'h15 || sync_err !== 1'b0 || locked !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL early_next: got valid=%b ch1=%h se=%b lk=%b expected 0010/15/0/1",
                  ch_valid, ch_data[9:5], sync_err, locked);
      end
   endtask

   task automatic test_missing_sync();
      applyStimulus(1'b1, 1'b0, 5'h16, 1'b1);
      applyStimulus(1'b1, 1'b0, 5'h17, 1'b0);
      n_checks++;
      if (frame_done !== 1'b1 || ch_valid !== 4'b1000) begin
         n_fail++; $display("[TB] FAIL missing_pre: got fd=%b valid=%b expected 1/1000", frame_done, ch_valid);
      end
      applyStimulus(1'b1, 1'b0, 5'h09, 1'b0);
      n_checks++;
      if (sync_err !== 1'b1 || locked !== 1'b0 || ch_valid !== '0 ||
          ch_data !== {5'h17, 5'h16, 5'h15, 5'h0A}) begin
         n_fail++;
         $display("[TB] FAIL missing_sync: got se=%b lk=%b valid=%b data=%h expected 1/0/0000/%h",
                  sync_err, locked, ch_valid, ch_data, {5'h17, 5'h16, 5'h15, 5'h0A});
      end
   endtask

   task automatic test_parity();
      logic [NCH-1:0] exp_par;
`ifdef TDM_PARITY_EN
      exp_par = 4'b0010;
`else
      exp_par = 4'b0000;
`endif
      test_reset();
      applyStimulus(1'b1, 1'b1, 5'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 5'h03, 1'b1);
      n_checks++;
      if (par_err !== exp_par || ch_data[9:5] !== 5'h03 || ch_valid !== 4'b0010) begin
         n_fail++;
         $display("[TB] FAIL parity_bad: got par=%b ch1=%h valid=%b expected %b/03/0010",
                  par_err, ch_data[9:5], ch_valid, exp_par);
      end
      applyStimulus(1'b1, 1'b0, 5'h07, 1'b1);
      n_checks++;
      if (par_err !== '0 || ch_data[14:10] !== 5'h07) begin
         n_fail++; $display("[TB] FAIL parity_good: got par=%b ch2=%h expected 0000/07", par_err, ch_data[14:10]);
      end
   endtask

   task automatic test_reset_midframe();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if ({ch_data, ch_valid, frame_done, sync_err, locked, par_err} !== '0) begin
         n_fail++;
         $display("[TB] FAIL midframe_reset: got data=%h valid=%b lk=%b expected all 0", ch_data, ch_valid, locked);
      end
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 5'h12, 1'b0);
      n_checks++;
      if (ch_valid !== '0 || locked !== 1'b0 || ch_data !== '0) begin
         n_fail++;
         $display("[TB] FAIL midframe_resume: got valid=%b lk=%b data=%h expected 0/0/0", ch_valid, locked, ch_data);
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         logic v, fs, p;
         logic [WIDTH-1:0] d;
         logic [VW-1:0] got;
         v  = ($urandom_range(0, 3) != 0);
         fs = (m_slot == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
         d  = WIDTH'($urandom);
         p  = ($urandom_range(0, 4) == 0) ? ~(^d) : ^d;
         applyStimulus(v, fs, d, p);
         got = {ch_data, ch_valid, frame_done, sync_err, locked, par_err};
         n_checks++;
         if (got !== model_vec()) begin
            n_fail++;
            bad++;
            if (bad <= 5)
               $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, got, model_vec());
         end
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b1;
      din        = '0;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      din_par    = 1'b0;
      model_reset();
      test_reset();
      test_basic_frame();
      test_gaps();
      test_hunt_discard();
      test_early_sync();
      test_missing_sync();
      test_parity();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tdm_demux_4ch.md
TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning the data word width (matches the 5-bit ALU result).
REQ-002 SHALL have parameter NCH, default 4, meaning the number of TDM slots per frame; it SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  WIDTH  TDM word for the current slot.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 frame_sync  input  1  qualified by din_valid; marks the word as slot 0.
REQ-008 din_par  input  1  even-parity bit over din; ignored unless TDM_PARITY_EN is defined.
REQ-009 ch_data  output  NCH*WIDTH  per-channel data registers; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 ch_valid  output  NCH  one-cycle pulse on bit k when channel k is updated.
REQ-011 frame_done  output  1  one-cycle pulse when slot NCH-1 of an aligned frame is captured.
REQ-012 locked  output  1  high while in state LOCKED.
REQ-013 sync_err  output  1  one-cycle pulse on a framing violation.
REQ-014 par_err  output  NCH  one-cycle pulse on bit k on a parity mismatch in channel k.

Function
REQ-015 SHALL implement a 2-state FSM: HUNT and LOCKED, with a slot counter of log2(NCH) bits.
REQ-016 All outputs SHALL be registered: latency is one clock from the accepted word to ch_data/ch_valid/frame_done/sync_err.
REQ-017 Cycles with din_valid=0 SHALL change no state; all pulse outputs SHALL be 0 in the following cycle.
REQ-018 In HUNT, words without frame_sync SHALL be discarded with no output pulses.
REQ-019 In HUNT, din_valid && frame_sync SHALL capture din into channel 0, pulse ch_valid[0], set slot to 1 and enter LOCKED.
REQ-020 In LOCKED, a valid word with slot != 0 and frame_sync=0 SHALL be written to channel slot, pulse ch_valid[slot], and increment slot modulo NCH.
REQ-021 Capturing slot NCH-1 SHALL pulse frame_done together with ch_valid[NCH-1]; slot wraps to 0.
REQ-022 In LOCKED, frame_sync with slot != 0 (early sync) SHALL pulse sync_err, treat the word as slot 0 (capture into channel 0, pulse ch_valid[0], slot=1), stay LOCKED, and emit no frame_done for the truncated frame.
REQ-023 In LOCKED, a valid word at slot 0 without frame_sync (missing sync) SHALL pulse sync_err, discard the word, and return to HUNT.
REQ-024 A valid word at slot 0 with frame_sync SHALL behave as REQ-020 for channel 0, with no error.
REQ-025 ch_data SHALL hold its last value until overwritten; it is never cleared outside reset.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state HUNT, slot 0, ch_data all zeros, and ch_valid, frame_done, locked, sync_err, par_err all 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release, the first accepted word SHALL require frame_sync.

Configuration
REQ-028 With TDM_PARITY_EN defined, each captured word SHALL be checked against even parity (XOR of din and din_par is 0); on mismatch, par_err[k] SHALL pulse alongside ch_valid[k], and the data SHALL still be captured.
REQ-029 Without TDM_PARITY_EN, par_err SHALL be constant 0, din_par SHALL be unused, and no parity logic SHALL be synthesized.

Structure
REQ-030 A shared package tdm_pkg SHALL hold the FSM state typedef (HUNT, LOCKED) and the default WIDTH/NCH constants.
REQ-031 One sub-module, tdm_slot_counter (modulo-NCH counter with load-to-1 and clear), is natural; the FSM and capture registers stay in the top.

Verification
REQ-032 Reset, then frame with sync, words 5'h01,5'h02,5'h03,5'h04 -> ch_valid 0001,0010,0100,1000 on consecutive cycles, frame_done with the last one, locked=1, ch_data = {04,03,02,01}.
REQ-033 Words 5'h1F,5'h1E without sync after reset -> no pulses, locked=0; the next sync word 5'h07 -> ch0=07, locked=1.
REQ-034 Locked, sync asserted on slot 2 with 5'h0A -> sync_err pulse, ch0=0A, no frame_done, next word lands in ch1.
REQ-035 Locked, slot-0 word without sync -> sync_err pulse, locked=0, word discarded, channels unchanged.
REQ-036 din_valid gaps of 3 cycles between slots -> identical captures to REQ-032, and no pulses during the gaps.
REQ-037 TDM_PARITY_EN: din=5'h03, din_par=1 on slot 1 -> par_err=0010 and ch1=03; with the macro undefined -> par_err=0. Reset asserted mid-frame -> all outputs 0 immediately.
